// File: rtl/video_sync_gen_pkg.sv
// Shared raster timing constants and the per-axis flag bundle.
// Imported by the sync generator, its axis counters and the interface.
package video_timing_pkg;

    localparam int DEF_H_TOTAL      = 455;
    localparam int DEF_H_ACTIVE     = 384;
    localparam int DEF_H_SYNC_START = 400;
    localparam int DEF_H_SYNC_LEN   = 32;
    localparam int DEF_V_TOTAL      = 262;
    localparam int DEF_V_ACTIVE     = 240;
    localparam int DEF_V_SYNC_START = 248;
    localparam int DEF_V_SYNC_LEN   = 4;

    localparam int H_CNT_W = $clog2(DEF_H_TOTAL);
    localparam int V_CNT_W = $clog2(DEF_V_TOTAL);

    typedef struct packed {
        logic last;
        logic sync;
        logic blank;
    } axis_flags_t;

endpackage

// File: rtl/video_sync_gen_if.sv
// Raster timing bundle published by video_sync_gen.
// master drives the counts and flags, slave consumes them.
interface video_sync_gen_if
    import video_timing_pkg::*;
#(
    parameter int HW = H_CNT_W,
    parameter int VW = V_CNT_W
);

    logic [HW-1:0] o_HCount;
    logic [VW-1:0] o_VCount;
    logic          o_HReset;
    logic          o_VReset;
    logic          o_HSync;
    logic          o_VSync;
    logic          o_HBlank;
    logic          o_VBlank;
    logic          o_Active;
    logic          o_CSync;

    modport master (
        output o_HCount, o_VCount,
        output o_HReset, o_VReset,
        output o_HSync, o_VSync,
        output o_HBlank, o_VBlank,
        output o_Active, o_CSync
    );

    modport slave (
        input o_HCount, o_VCount,
        input o_HReset, o_VReset,
        input o_HSync, o_VSync,
        input o_HBlank, o_VBlank,
        input o_Active, o_CSync
    );

endinterface

// File: rtl/timing_axis_counter.sv
// One raster axis: wrapping counter plus last/sync/blank flags
// registered from the next count so they align with the count.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int TOTAL      = DEF_H_TOTAL,
    parameter int ACTIVE     = DEF_H_ACTIVE,
    parameter int SYNC_START = DEF_H_SYNC_START,
    parameter int SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int W          = $clog2(TOTAL)
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        advance,
    output logic [W-1:0] count,
    output logic        wrap,
    output axis_flags_t flags,
    output axis_flags_t nxt_flags
);

    // One extra bit so SYNC_START+SYNC_LEN == TOTAL stays representable
    localparam logic [W:0] LAST = (W+1)'(TOTAL - 1);
    localparam logic [W:0] ACT  = (W+1)'(ACTIVE);
    localparam logic [W:0] SS   = (W+1)'(SYNC_START);
    localparam logic [W:0] SE   = (W+1)'(SYNC_START + SYNC_LEN);

    localparam axis_flags_t RST_FLAGS = '{
        last:  1'b0,
        sync:  (SYNC_START == 0),
        blank: (ACTIVE == 0)
    };

    if (TOTAL < 2) begin : g_bad_total
        $fatal(1, "timing_axis_counter: TOTAL must be >= 2");
    end
    if (ACTIVE >= TOTAL) begin : g_bad_active
        $fatal(1, "timing_axis_counter: ACTIVE must be < TOTAL");
    end
    if (SYNC_LEN < 1) begin : g_bad_len
        $fatal(1, "timing_axis_counter: SYNC_LEN must be >= 1");
    end
    if (SYNC_START + SYNC_LEN > TOTAL) begin : g_bad_sync
        $fatal(1, "timing_axis_counter: sync window exceeds TOTAL");
    end

    logic [W-1:0] nxt_count;
    logic [W:0]   nxt_ext;

    assign wrap    = advance && ({1'b0, count} == LAST);
    assign nxt_ext = {1'b0, nxt_count};

    always_comb begin
        nxt_count = count;
        if (wrap) begin
            nxt_count = '0;
        end else if (advance) begin
            nxt_count = count + W'(1);
        end
    end

    always_comb begin
        nxt_flags       = '0;
        nxt_flags.last  = (nxt_ext == LAST);
        nxt_flags.sync  = (nxt_ext >= SS) && (nxt_ext < SE);
        nxt_flags.blank = (nxt_ext >= ACT);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            count <= '0;
            flags <= RST_FLAGS;
        end else begin
            count <= nxt_count;
            flags <= nxt_flags;
        end
    end

endmodule

// File: rtl/video_sync_gen.sv
// Raster sync generator: line/frame strobes, syncs, blanking, counts.
// Define VIDEO_SYNC_GEN_CSYNC_EN to build the HSync^VSync composite.
module video_sync_gen
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN
) (
    input logic              i_Clk,
    input logic              i_Reset,
    video_sync_gen_if.master vid
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic          h_wrap;
    logic          v_wrap;
    axis_flags_t   h_flags;
    axis_flags_t   h_nxt;
    axis_flags_t   v_flags;
    axis_flags_t   v_nxt;
    logic          vreset;
    logic          active;
    logic          csync;
    logic          unused_ok;

    timing_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_SYNC_START),
        .SYNC_LEN   (H_SYNC_LEN),
        .W          (HW)
    ) u_h (
        .i_Clk     (i_Clk),
        .i_Reset   (i_Reset),
        .advance   (1'b1),
        .count     (h_count),
        .wrap      (h_wrap),
        .flags     (h_flags),
        .nxt_flags (h_nxt)
    );

    timing_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_SYNC_START),
        .SYNC_LEN   (V_SYNC_LEN),
        .W          (VW)
    ) u_v (
        .i_Clk     (i_Clk),
        .i_Reset   (i_Reset),
        .advance   (h_wrap),
        .count     (v_count),
        .wrap      (v_wrap),
        .flags     (v_flags),
        .nxt_flags (v_nxt)
    );

    // Cross-axis flags are decoded from both next counts
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            vreset <= 1'b0;
            active <= 1'b1;
        end else begin
            vreset <= h_nxt.last & v_nxt.last;
            active <= ~h_nxt.blank & ~v_nxt.blank;
        end
    end

`ifdef VIDEO_SYNC_GEN_CSYNC_EN
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            csync <= 1'b0;
        end else begin
            csync <= h_nxt.sync ^ v_nxt.sync;
        end
    end
`else
    assign csync = 1'b0;
`endif

    assign unused_ok = ^{v_wrap, v_flags.last, h_nxt.sync, v_nxt.sync};

    assign vid.o_HCount = h_count;
    assign vid.o_VCount = v_count;
    assign vid.o_HReset = h_flags.last;
    assign vid.o_VReset = vreset;
    assign vid.o_HSync  = h_flags.sync;
    assign vid.o_VSync  = v_flags.sync;
    assign vid.o_HBlank = h_flags.blank;
    assign vid.o_VBlank = v_flags.blank;
    assign vid.o_Active = active;
    assign vid.o_CSync  = csync;

endmodule
